// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch sequencing for the IF stage.
//
// Decides each cycle whether the PC advances sequentially or loads a redirect
// target. It also decides whether a fetched instruction goes to decode, and
// whether the IF/ID register must be flushed. Redirects that arrive while
// instruction memory is not ready are held in a pending register, and are
// applied on the next ready cycle.
//
// Optional feature: define FETCH_CTRL_PERF_EN to add the performance counters
// (stall_cycles, wait_cycles, redirect_count). With the macro undefined, those
// ports and counters do not exist.
//
// Ports:
//   clk             in   clock, all state updates on posedge
//   rst             in   synchronous, active-high reset
//   stall           in   hazard unit requests fetch hold
//   redirect        in   execute stage reports taken branch / jump
//   redirect_target in   redirect destination (PC_WIDTH)
//   imem_rdy        in   instruction memory returns data this cycle
//   imem_req        out  fetch request to instruction memory
//   pc_en           out  program counter update enable
//   pc_src          out  PC mux select, 1 = pc_branch
//   pc_branch       out  PC load value when pc_src = 1 (PC_WIDTH)
//   if_valid        out  fetched instruction handed to decode this cycle
//   flush           out  kill wrong-path instruction in IF/ID
//   dbg_state       out  current FSM state (BOOT=0, FETCH=1, WAIT=2)
//   stall_cycles    out  [FETCH_CTRL_PERF_EN] held cycles caused by stall
//   wait_cycles     out  [FETCH_CTRL_PERF_EN] cycles spent in WAIT
//   redirect_count  out  [FETCH_CTRL_PERF_EN] redirects applied to the PC
//
// Handshake: imem_req is a request level and imem_rdy is the memory's
// completion strobe. A cycle with imem_req=1 and imem_rdy=1 delivers one
// instruction. That cycle is consumed as exactly one of three things: a
// sequential advance, a redirect (flush), or a stall hold.
module fetch_ctrl #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [PC_WIDTH-1:0]  redirect_target,
  input  logic                 imem_rdy,
  output logic                 imem_req,
  output logic                 pc_en,
  output logic                 pc_src,
  output logic [PC_WIDTH-1:0]  pc_branch,
  output logic                 if_valid,
  output logic                 flush,
  output logic [1:0]           dbg_state
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] wait_cycles,
  output logic [CNT_WIDTH-1:0] redirect_count
`endif
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                pend_q, pend_d;
  logic [PC_WIDTH-1:0] pend_tgt_q, pend_tgt_d;

  logic active;      // FETCH or WAIT, and not held in reset
  logic redir_any;   // a redirect is arriving now or already pending
  logic apply_redir; // a redirect is loaded into the PC this cycle

  assign active      = !rst && (state_q == ST_FETCH || state_q == ST_WAIT);
  assign redir_any   = redirect || pend_q;
  assign apply_redir = active && imem_rdy && redir_any;

  // A redirect overrides stall. The wrong-path instruction is flushed, so the
  // hazard that caused the stall no longer matters.
  always_comb begin
    imem_req  = active && !(stall && !redir_any);
    pc_en     = active && imem_rdy && (apply_redir || !stall);
    pc_src    = apply_redir;
    if_valid  = active && imem_rdy && !stall && !apply_redir;
    flush     = apply_redir;
    dbg_state = state_q;
    if (rst) begin
      pc_branch = '0;
    end else if (redirect) begin
      pc_branch = redirect_target;
    end else begin
      pc_branch = pend_tgt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: if (!imem_rdy) state_d = ST_WAIT;
      ST_WAIT:  if (imem_rdy)  state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  // Pending redirect. A new redirect always overwrites the stored target, so
  // the last target wins. Applying a redirect retires whatever was pending.
  always_comb begin
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (redirect && !apply_redir) begin
      pend_d     = 1'b1;
      pend_tgt_d = redirect_target;
    end else if (apply_redir) begin
      pend_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, wait_cnt_q, redir_cnt_q;
  logic                 stall_hold;

  // A cycle counts as a stall hold only when stall is the reason the PC is
  // frozen. A redirect in the same cycle takes priority and is not counted.
  assign stall_hold = active && stall && !redirect && !apply_redir;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (stall_hold)          stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (state_q == ST_WAIT)  wait_cnt_q  <= wait_cnt_q + CNT_WIDTH'(1);
      if (apply_redir)         redir_cnt_q <= redir_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles   = stall_cnt_q;
  assign wait_cycles    = wait_cnt_q;
  assign redirect_count = redir_cnt_q;
`endif

endmodule
